// File: rtl/hwpe_tcdm_slice_wrap.sv
// hwpe_tcdm_slice_wrap
// TCDM decoupling stage between an HWPE engine and the cluster interconnect.
// Each master port has its own request FIFO, an outstanding-transaction
// limiter and a registered response path, so no combinational path runs
// from the interconnect grant back to the engine grant.
// Optional feature: define HWPE_TCDM_SLICE_PERF_EN to build the per-port
// saturating stall counters; otherwise perf_stall_o is tied to zero.

module hwpe_tcdm_slice_wrap #(
    parameter int unsigned MP         = 4,
    parameter int unsigned DW         = 32,
    parameter int unsigned AW         = 32,
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned MAX_OUTST  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     clear_i,
    input  logic [MP-1:0]            eng_req_i,
    output logic [MP-1:0]            eng_gnt_o,
    input  logic [MP-1:0][AW-1:0]    eng_add_i,
    input  logic [MP-1:0]            eng_wen_i,
    input  logic [MP-1:0][DW/8-1:0]  eng_be_i,
    input  logic [MP-1:0][DW-1:0]    eng_data_i,
    output logic [MP-1:0][DW-1:0]    eng_r_data_o,
    output logic [MP-1:0]            eng_r_valid_o,
    output logic [MP-1:0]            tcdm_req_o,
    input  logic [MP-1:0]            tcdm_gnt_i,
    output logic [MP-1:0][AW-1:0]    tcdm_add_o,
    output logic [MP-1:0]            tcdm_wen_o,
    output logic [MP-1:0][DW/8-1:0]  tcdm_be_o,
    output logic [MP-1:0][DW-1:0]    tcdm_data_o,
    input  logic [MP-1:0][DW-1:0]    tcdm_r_data_i,
    input  logic [MP-1:0]            tcdm_r_valid_i,
    output logic [MP-1:0]            err_o,
    output logic [MP-1:0][31:0]      perf_stall_o
);

    localparam int unsigned BW = DW / 8;
    localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OW = $clog2(MAX_OUTST + 1);

    typedef struct packed {
        logic [AW-1:0] add;
        logic          wen;
        logic [BW-1:0] be;
        logic [DW-1:0] data;
    } req_t;

    // Pointer advance with explicit wrap so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (p == PW'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + PW'(1);
    endfunction

    for (genvar i = 0; i < MP; i++) begin : gen_port

        req_t          mem [FIFO_DEPTH];
        req_t          wr_req;
        req_t          head;
        logic [PW-1:0] wr_ptr;
        logic [PW-1:0] rd_ptr;
        logic [CW-1:0] count;
        logic [OW-1:0] outst;
        logic          full;
        logic          empty;
        logic          push;
        logic          pop;
        logic          r_exp;
        logic          r_unexp;
        logic          r_valid_q;
        logic [DW-1:0] r_data_q;
        logic          err_q;

        assign full  = (count == CW'(FIFO_DEPTH));
        assign empty = (count == '0);

        // Engine grant depends only on local FIFO state, never on the interconnect.
        assign eng_gnt_o[i] = rst_ni & ~full & ~clear_i;
        assign push         = eng_req_i[i] & eng_gnt_o[i];

        assign tcdm_req_o[i] = rst_ni & ~empty & (outst < OW'(MAX_OUTST));
        assign pop           = tcdm_req_o[i] & tcdm_gnt_i[i];

        assign wr_req = '{add: eng_add_i[i], wen: eng_wen_i[i],
                          be: eng_be_i[i], data: eng_data_i[i]};
        assign head   = mem[rd_ptr];

        // Fields are masked while no request is presented so idle outputs read zero.
        assign tcdm_add_o[i]  = tcdm_req_o[i] ? head.add  : '0;
        assign tcdm_wen_o[i]  = tcdm_req_o[i] ? head.wen  : 1'b0;
        assign tcdm_be_o[i]   = tcdm_req_o[i] ? head.be   : '0;
        assign tcdm_data_o[i] = tcdm_req_o[i] ? head.data : '0;

        assign r_exp   = tcdm_r_valid_i[i] & (outst != '0);
        assign r_unexp = tcdm_r_valid_i[i] & (outst == '0);

        // FIFO storage: payload only, validity is tracked by count.
        always_ff @(posedge clk_i) begin
            if (push) begin
                mem[wr_ptr] <= wr_req;
            end
        end

        // FIFO pointers and occupancy; clear empties the queue in one cycle.
        always_ff @(posedge clk_i) begin
            if (!rst_ni || clear_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= ptr_next(wr_ptr);
                end
                if (pop) begin
                    rd_ptr <= ptr_next(rd_ptr);
                end
                if (push && !pop) begin
                    count <= count + CW'(1);
                end else if (!push && pop) begin
                    count <= count - CW'(1);
                end
            end
        end

        // Outstanding counter: issued grants minus legitimate responses, untouched by clear.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                outst <= '0;
            end else if (pop && !r_exp) begin
                outst <= outst + OW'(1);
            end else if (!pop && r_exp) begin
                outst <= outst - OW'(1);
            end
        end

        // Sticky error when a response arrives with nothing outstanding.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                err_q <= 1'b0;
            end else if (r_unexp) begin
                err_q <= 1'b1;
            end
        end

        // Response path registered once; data holds its last value when valid is low.
        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                r_valid_q <= 1'b0;
                r_data_q  <= '0;
            end else begin
                r_valid_q <= tcdm_r_valid_i[i];
                if (tcdm_r_valid_i[i]) begin
                    r_data_q <= tcdm_r_data_i[i];
                end
            end
        end

        assign eng_r_valid_o[i] = r_valid_q;
        assign eng_r_data_o[i]  = r_data_q;
        assign err_o[i]         = err_q;

`ifdef HWPE_TCDM_SLICE_PERF_EN
        logic [31:0] stall_cnt;

        // Count cycles where a request waits on the interconnect, saturating at all-ones.
        always_ff @(posedge clk_i) begin
            if (!rst_ni || clear_i) begin
                stall_cnt <= '0;
            end else if (tcdm_req_o[i] && !tcdm_gnt_i[i] && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end

        assign perf_stall_o[i] = stall_cnt;
`else
        assign perf_stall_o[i] = '0;
`endif

    end

endmodule

// File: tb/tb_hwpe_tcdm_slice_wrap.sv
// tb_hwpe_tcdm_slice_wrap
// Self-checking bench: directed scenarios followed by random traffic, all
// compared every cycle against a queue-based transaction model.
// Honours HWPE_TCDM_SLICE_PERF_EN when the design is built with it.

module tb_hwpe_tcdm_slice_wrap;

    localparam int unsigned MP         = 4;
    localparam int unsigned DW         = 32;
    localparam int unsigned AW         = 32;
    localparam int unsigned FIFO_DEPTH = 2;
    localparam int unsigned MAX_OUTST  = 4;
    localparam int unsigned BW         = DW / 8;

`ifdef HWPE_TCDM_SLICE_PERF_EN
    localparam bit PERF_ON = 1'b1;
`else
    localparam bit PERF_ON = 1'b0;
`endif

    logic                    clk_i;
    logic                    rst_ni;
    logic                    clear_i;
    logic [MP-1:0]           eng_req_i;
    logic [MP-1:0]           eng_gnt_o;
    logic [MP-1:0][AW-1:0]   eng_add_i;
    logic [MP-1:0]           eng_wen_i;
    logic [MP-1:0][BW-1:0]   eng_be_i;
    logic [MP-1:0][DW-1:0]   eng_data_i;
    logic [MP-1:0][DW-1:0]   eng_r_data_o;
    logic [MP-1:0]           eng_r_valid_o;
    logic [MP-1:0]           tcdm_req_o;
    logic [MP-1:0]           tcdm_gnt_i;
    logic [MP-1:0][AW-1:0]   tcdm_add_o;
    logic [MP-1:0]           tcdm_wen_o;
    logic [MP-1:0][BW-1:0]   tcdm_be_o;
    logic [MP-1:0][DW-1:0]   tcdm_data_o;
    logic [MP-1:0][DW-1:0]   tcdm_r_data_i;
    logic [MP-1:0]           tcdm_r_valid_i;
    logic [MP-1:0]           err_o;
    logic [MP-1:0][31:0]     perf_stall_o;

    hwpe_tcdm_slice_wrap #(
        .MP(MP), .DW(DW), .AW(AW), .FIFO_DEPTH(FIFO_DEPTH), .MAX_OUTST(MAX_OUTST)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
        .eng_req_i(eng_req_i), .eng_gnt_o(eng_gnt_o), .eng_add_i(eng_add_i),
        .eng_wen_i(eng_wen_i), .eng_be_i(eng_be_i), .eng_data_i(eng_data_i),
        .eng_r_data_o(eng_r_data_o), .eng_r_valid_o(eng_r_valid_o),
        .tcdm_req_o(tcdm_req_o), .tcdm_gnt_i(tcdm_gnt_i), .tcdm_add_o(tcdm_add_o),
        .tcdm_wen_o(tcdm_wen_o), .tcdm_be_o(tcdm_be_o), .tcdm_data_o(tcdm_data_o),
        .tcdm_r_data_i(tcdm_r_data_i), .tcdm_r_valid_i(tcdm_r_valid_i),
        .err_o(err_o), .perf_stall_o(perf_stall_o)
    );

    typedef struct packed {
        logic [AW-1:0] add;
        logic          wen;
        logic [BW-1:0] be;
        logic [DW-1:0] data;
    } txn_t;

    // Reference model: pending requests per port, outstanding count, error flag,
    // last response and stall count.
    txn_t          mq [MP][$];
    int            m_outst [MP];
    bit            m_err [MP];
    bit            m_rv [MP];
    logic [DW-1:0] m_rd [MP];
    longint        m_perf [MP];

    int n_checks = 0;
    int n_fail   = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < MP; p++) begin
            mq[p].delete();
            m_outst[p] = 0;
            m_err[p]   = 1'b0;
            m_rv[p]    = 1'b0;
            m_rd[p]    = '0;
            m_perf[p]  = 0;
        end
    endtask

    task automatic drive_idle();
        eng_req_i      = '0;
        tcdm_gnt_i     = '0;
        tcdm_r_valid_i = '0;
        clear_i        = 1'b0;
    endtask

    // One clock cycle: compare outputs against the model, advance the model, clock.
    task automatic step();
        logic [MP-1:0] eg;
        logic [MP-1:0] er;
        txn_t h;
        txn_t t;
        #1;
        for (int p = 0; p < MP; p++) begin
            eg[p] = rst_ni && (mq[p].size() < FIFO_DEPTH) && !clear_i;
            er[p] = rst_ni && (mq[p].size() > 0) && (m_outst[p] < MAX_OUTST);
            check($sformatf("p%0d_eng_gnt", p), eng_gnt_o[p], eg[p]);
            check($sformatf("p%0d_tcdm_req", p), tcdm_req_o[p], er[p]);
            check($sformatf("p%0d_r_valid", p), eng_r_valid_o[p], m_rv[p]);
            check($sformatf("p%0d_r_data", p), eng_r_data_o[p], m_rd[p]);
            check($sformatf("p%0d_err", p), err_o[p], m_err[p]);
            check($sformatf("p%0d_perf", p), perf_stall_o[p], PERF_ON ? m_perf[p] : 0);
            if (er[p]) begin
                h = mq[p][0];
                check($sformatf("p%0d_tcdm_add", p), tcdm_add_o[p], h.add);
                check($sformatf("p%0d_tcdm_wen", p), tcdm_wen_o[p], h.wen);
                check($sformatf("p%0d_tcdm_be", p), tcdm_be_o[p], h.be);
                check($sformatf("p%0d_tcdm_data", p), tcdm_data_o[p], h.data);
            end
        end
        for (int p = 0; p < MP; p++) begin
            if (!rst_ni) begin
                mq[p].delete();
                m_outst[p] = 0;
                m_err[p]   = 1'b0;
                m_rv[p]    = 1'b0;
                m_rd[p]    = '0;
                m_perf[p]  = 0;
            end else begin
                if (clear_i) begin
                    m_perf[p] = 0;
                end else if (er[p] && !tcdm_gnt_i[p] && m_perf[p] < 64'hFFFF_FFFF) begin
                    m_perf[p]++;
                end
                m_rv[p] = tcdm_r_valid_i[p];
                if (tcdm_r_valid_i[p]) begin
                    m_rd[p] = tcdm_r_data_i[p];
                    if (m_outst[p] == 0) m_err[p] = 1'b1;
                    else m_outst[p]--;
                end
                if (er[p] && tcdm_gnt_i[p]) begin
                    m_outst[p]++;
                    void'(mq[p].pop_front());
                end
                if (clear_i) begin
                    mq[p].delete();
                end else if (eng_req_i[p] && eg[p]) begin
                    t = '{add: eng_add_i[p], wen: eng_wen_i[p], be: eng_be_i[p], data: eng_data_i[p]};
                    mq[p].push_back(t);
                end
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus_req(input int p, input logic [AW-1:0] a, input logic w,
                                     input logic [DW-1:0] d);
        eng_req_i[p]  = 1'b1;
        eng_add_i[p]  = a;
        eng_wen_i[p]  = w;
        eng_be_i[p]   = BW'($urandom);
        eng_data_i[p] = d;
    endtask

    // Grant everything and return every outstanding response, with a cycle bound.
    task automatic drain();
        int cyc;
        bit busy;
        cyc = 0;
        eng_req_i  = '0;
        clear_i    = 1'b0;
        tcdm_gnt_i = '1;
        busy = 1'b1;
        while (busy && cyc < 60) begin
            busy = 1'b0;
            for (int p = 0; p < MP; p++) begin
                tcdm_r_valid_i[p] = (m_outst[p] > 0);
                tcdm_r_data_i[p]  = DW'($urandom);
                if (mq[p].size() > 0 || m_outst[p] > 0) busy = 1'b1;
            end
            if (busy) step();
            cyc++;
        end
        check("drain_done", busy, 1'b0);
        drive_idle();
    endtask

    initial begin
        int issued;
        logic [2:0] gnt_seen;

        rst_ni        = 1'b0;
        drive_idle();
        eng_add_i     = '0;
        eng_wen_i     = '0;
        eng_be_i      = '0;
        eng_data_i    = '0;
        tcdm_r_data_i = '0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;

        // Reset: everything reads zero, grant held low.
        eng_req_i = '1;
        step();
        check("reset_gnt", eng_gnt_o, '0);
        check("reset_req", tcdm_req_o, '0);
        eng_req_i = '0;
        rst_ni = 1'b1;
        step();

        // Single write on port 0 with immediate grant.
        tcdm_gnt_i[0] = 1'b1;
        applyStimulus_req(0, 32'h100, 1'b0, 32'hDEAD);
        step();
        eng_req_i[0] = 1'b0;
        #1;
        check("wr_tcdm_req_next", tcdm_req_o[0], 1'b1);
        check("wr_tcdm_add", tcdm_add_o[0], 32'h100);
        check("wr_tcdm_data", tcdm_data_o[0], 32'hDEAD);
        step();
        tcdm_gnt_i[0] = 1'b0;
        step();
        step();
        tcdm_r_valid_i[0] = 1'b1;
        tcdm_r_data_i[0]  = 32'hBEEF;
        step();
        tcdm_r_valid_i[0] = 1'b0;
        #1;
        check("wr_resp_valid", eng_r_valid_o[0], 1'b1);
        check("wr_resp_data", eng_r_data_o[0], 32'hBEEF);
        step();

        // FIFO fills with grant withheld; third request waits for a pop.
        for (int k = 0; k < 3; k++) begin
            applyStimulus_req(1, 32'h200 + 32'(k * 4), 1'b1, DW'($urandom));
            #1;
            gnt_seen[k] = eng_gnt_o[1];
            step();
        end
        check("full_gnt_pattern", gnt_seen, 3'b011);
        tcdm_gnt_i[1] = 1'b1;
        #1;
        check("full_pop_same_cycle_gnt", eng_gnt_o[1], 1'b0);
        step();
        tcdm_gnt_i[1] = 1'b0;
        #1;
        check("full_after_pop_gnt", eng_gnt_o[1], 1'b1);
        step();
        eng_req_i[1] = 1'b0;
        drain();

        // Outstanding limit: six reads, responses withheld.
        issued = 0;
        tcdm_gnt_i[0] = 1'b1;
        for (int k = 0; k < 12; k++) begin
            if (k < 6 || mq[0].size() + m_outst[0] < 6)
                applyStimulus_req(0, 32'h300 + 32'(k * 4), 1'b1, '0);
            else
                eng_req_i[0] = 1'b0;
            if (mq[0].size() + m_outst[0] >= 6) eng_req_i[0] = 1'b0;
            #1;
            if (tcdm_req_o[0]) issued++;
            step();
        end
        eng_req_i[0] = 1'b0;
        check("outst_issued", issued, 4);
        check("outst_req_dropped", tcdm_req_o[0], 1'b0);
        tcdm_r_valid_i[0] = 1'b1;
        tcdm_r_data_i[0]  = 32'h5555;
        step();
        tcdm_r_valid_i[0] = 1'b0;
        #1;
        check("outst_fifth_issue", tcdm_req_o[0], 1'b1);
        step();
        drain();

        // Unexpected response on idle port 2.
        tcdm_r_valid_i[2] = 1'b1;
        tcdm_r_data_i[2]  = 32'h77;
        step();
        tcdm_r_valid_i[2] = 1'b0;
        #1;
        check("err_port2_set", err_o, 4'b0100);
        repeat (3) step();
        check("err_port2_sticky", err_o[2], 1'b1);

        // Clear with two queued and one outstanding on port 3.
        applyStimulus_req(3, 32'h400, 1'b1, '0);
        step();
        applyStimulus_req(3, 32'h404, 1'b1, '0);
        tcdm_gnt_i[3] = 1'b1;
        step();
        applyStimulus_req(3, 32'h408, 1'b1, '0);
        tcdm_gnt_i[3] = 1'b0;
        step();
        eng_req_i[3] = 1'b0;
        clear_i = 1'b1;
        step();
        clear_i = 1'b0;
        #1;
        check("clear_fifo_empty", tcdm_req_o[3], 1'b0);
        tcdm_r_valid_i[3] = 1'b1;
        tcdm_r_data_i[3]  = 32'h1234;
        step();
        tcdm_r_valid_i[3] = 1'b0;
        #1;
        check("clear_resp_delivered", eng_r_valid_o[3], 1'b1);
        check("clear_no_err", err_o[3], 1'b0);
        step();

        // Stall counter: seven cycles of request without grant on port 1.
        applyStimulus_req(1, 32'h500, 1'b0, 32'hCAFE);
        step();
        eng_req_i[1] = 1'b0;
        repeat (7) step();
        check("perf_port1", perf_stall_o[1], PERF_ON ? 32'd7 : 32'd0);
        drain();

        // Random traffic on all ports.
        for (int c = 0; c < 400; c++) begin
            for (int p = 0; p < MP; p++) begin
                eng_req_i[p]      = $urandom_range(0, 1) == 1;
                eng_add_i[p]      = AW'($urandom);
                eng_wen_i[p]      = $urandom_range(0, 1) == 1;
                eng_be_i[p]       = BW'($urandom);
                eng_data_i[p]     = DW'($urandom);
                tcdm_gnt_i[p]     = $urandom_range(0, 2) != 0;
                tcdm_r_valid_i[p] = (m_outst[p] > 0) && ($urandom_range(0, 2) == 0);
                tcdm_r_data_i[p]  = DW'($urandom);
            end
            clear_i = $urandom_range(0, 31) == 0;
            step();
        end
        drain();

        // Reset clears the sticky error.
        rst_ni = 1'b0;
        step();
        rst_ni = 1'b1;
        #1;
        check("reset_clears_err", err_o, '0);
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
